// File: rtl/tpm_io_pkg.sv
// rtl/tpm_io_pkg.sv - shared TPM I/O constants, arbiter state encoding
//
// Purpose : TPM_ACCESS bit positions, default locality count and the
//           locality arbiter state type, shared by the TPM I/O front end.
// Ports   : none (package).

package tpm_io_pkg;

  // TPM_ACCESS register bit positions
  localparam int ACC_VALID   = 7;
  localparam int ACC_ACTIVE  = 5;
  localparam int ACC_SEIZED  = 4;
  localparam int ACC_SEIZE   = 3;
  localparam int ACC_PENDING = 2;
  localparam int ACC_REQUSE  = 1;

  // Default number of localities (at most 8)
  localparam int NUM_LOC_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ACTIVE      = 2'd1,
    ST_RELINQ_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tpm_loc_prio_enc.sv
// rtl/tpm_loc_prio_enc.sv - highest-set-bit priority encoder
//
// Purpose : returns the index of the highest set bit of i_vec, used to pick
//           the winning locality among pending requests.
// Ports   : i_vec   - request vector, W bits
//           o_valid - at least one bit set
//           o_idx   - index of the highest set bit (0 when none)

module tpm_loc_prio_enc #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_vec,
  output logic         o_valid,
  output logic [2:0]   o_idx
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 3'd0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) begin
        o_valid = 1'b1;
        o_idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/tpm_locality_arb.sv
// rtl/tpm_locality_arb.sv - TPM locality arbiter and TPM_ACCESS state
//
// Purpose : owns requestUse / activeLocality / beenSeized / pendingRequest
//           state per locality and decides which locality drives the
//           FIFO/CRB datapath. Ownership changes wait for cmd_busy to drop,
//           except a seize, which preempts at once and pulses o_abort.
// Config  : TPM_LOC_SEIZE_EN - when defined, seize and beenSeized are
//           implemented; otherwise seize is ignored, been_seized stays 0
//           and o_abort is tied 0.
// Ports   : i_clock, i_reset (async, active-high)
//           i_acc_wr, i_acc_loc, i_acc_wdata - TPM_ACCESS write port
//           i_acc_rd_loc / o_acc_rdata      - combinational TPM_ACCESS read
//           i_cmd_busy                      - CRB executing a command
//           o_locality                      - one-hot active locality
//           o_active_valid                  - some locality is active
//           o_req_pending, o_been_seized    - per-locality flags
//           o_abort                         - seize-during-command pulse

module tpm_locality_arb
  import tpm_io_pkg::*;
#(
  parameter int NUM_LOC = NUM_LOC_DEFAULT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_acc_wr,
  input  logic [2:0]         i_acc_loc,
  input  logic [7:0]         i_acc_wdata,
  input  logic [2:0]         i_acc_rd_loc,
  output logic [7:0]         o_acc_rdata,
  input  logic               i_cmd_busy,
  output logic [7:0]         o_locality,
  output logic               o_active_valid,
  output logic [NUM_LOC-1:0] o_req_pending,
  output logic [NUM_LOC-1:0] o_been_seized,
  output logic               o_abort
);

  localparam logic [3:0]         LOC_LIMIT = 4'(NUM_LOC);
  localparam logic [NUM_LOC-1:0] ONE       = {{(NUM_LOC-1){1'b0}}, 1'b1};

  arb_state_e         r_state;
  logic [2:0]         r_active;
  logic [NUM_LOC-1:0] r_req;
  logic [NUM_LOC-1:0] r_seized;
  logic               r_abort;
  logic [7:0]         r_locality;
  logic               r_active_valid;

  arb_state_e         w_state_nxt;
  logic [2:0]         w_active_nxt;
  logic [NUM_LOC-1:0] w_req_wr;
  logic [NUM_LOC-1:0] w_req_nxt;
  logic [NUM_LOC-1:0] w_seized_nxt;
  logic               w_abort_nxt;

  logic               w_wr_ok;
  logic [NUM_LOC-1:0] w_wr_mask;
  logic [NUM_LOC-1:0] w_act_mask;
  logic               w_is_owner;
  logic               w_seize;
  logic               w_relinq;
  logic               w_grant_valid;
  logic [2:0]         w_grant_idx;
  logic               w_rd_ok;
  logic [NUM_LOC-1:0] w_rd_mask;
  logic               w_unused_wdata;

  // Writes to localities beyond NUM_LOC produce an all-zero mask, so every
  // per-locality update below is automatically a no-op for them.
  assign w_wr_ok    = i_acc_wr && ({1'b0, i_acc_loc} < LOC_LIMIT);
  assign w_wr_mask  = w_wr_ok ? (ONE << i_acc_loc) : '0;
  assign w_act_mask = ONE << r_active;
  assign w_is_owner = (r_state != ST_IDLE) && (i_acc_loc == r_active);

  // Reserved data bits are don't-care.
  assign w_unused_wdata = ^i_acc_wdata;

`ifdef TPM_LOC_SEIZE_EN
  assign w_seize = w_wr_ok && i_acc_wdata[ACC_SEIZE] &&
                   (r_state != ST_IDLE) && (i_acc_loc > r_active);
`else
  assign w_seize = 1'b0;
`endif

  // Relinquish only counts when no seize wins the same write.
  assign w_relinq = !w_seize && w_wr_ok && i_acc_wdata[ACC_ACTIVE] && w_is_owner;

  // Request vector after this cycle's write. Computed ahead of the grant so a
  // request written while idle is granted in the very next cycle.
  always_comb begin
    w_req_wr = r_req;
    if (w_seize) begin
      w_req_wr = r_req & ~w_wr_mask;
    end else if (w_wr_ok && i_acc_wdata[ACC_ACTIVE]) begin
      if (!w_is_owner) begin
        w_req_wr = r_req & ~w_wr_mask;
      end
    end else if (w_wr_ok && i_acc_wdata[ACC_REQUSE] && !w_is_owner) begin
      w_req_wr = r_req | w_wr_mask;
    end
  end

  tpm_loc_prio_enc #(
    .W (NUM_LOC)
  ) u_prio_enc (
    .i_vec   (w_req_wr),
    .o_valid (w_grant_valid),
    .o_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_req_nxt    = w_req_wr;
    w_seized_nxt = r_seized;
    w_abort_nxt  = 1'b0;

    if (w_seize) begin
      w_state_nxt  = ST_ACTIVE;
      w_active_nxt = i_acc_loc;
      w_seized_nxt = r_seized | w_act_mask;
      w_abort_nxt  = i_cmd_busy;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid && !i_cmd_busy) begin
            w_state_nxt  = ST_ACTIVE;
            w_active_nxt = w_grant_idx;
            w_req_nxt    = w_req_wr & ~(ONE << w_grant_idx);
          end
        end
        ST_ACTIVE: begin
          if (w_relinq) begin
            w_state_nxt = i_cmd_busy ? ST_RELINQ_WAIT : ST_IDLE;
          end
        end
        ST_RELINQ_WAIT: begin
          if (!i_cmd_busy) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

`ifdef TPM_LOC_SEIZE_EN
    if (w_wr_ok && i_acc_wdata[ACC_SEIZED]) begin
      w_seized_nxt = w_seized_nxt & ~w_wr_mask;
    end
`else
    w_seized_nxt = '0;
    w_abort_nxt  = 1'b0;
`endif
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_active       <= 3'd0;
      r_req          <= '0;
      r_seized       <= '0;
      r_abort        <= 1'b0;
      r_locality     <= 8'd0;
      r_active_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_active       <= w_active_nxt;
      r_req          <= w_req_nxt;
      r_seized       <= w_seized_nxt;
      r_abort        <= w_abort_nxt;
      r_locality     <= (w_state_nxt == ST_IDLE) ? 8'd0 : (8'd1 << w_active_nxt);
      r_active_valid <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_locality     = r_locality;
  assign o_active_valid = r_active_valid;
  assign o_req_pending  = r_req;
  assign o_been_seized  = r_seized;
  assign o_abort        = r_abort;

  assign w_rd_ok   = ({1'b0, i_acc_rd_loc} < LOC_LIMIT);
  assign w_rd_mask = ONE << i_acc_rd_loc;

  always_comb begin
    o_acc_rdata = 8'd0;
    if (!w_rd_ok) begin
      o_acc_rdata = 8'hFF;
    end else begin
      o_acc_rdata[ACC_VALID]   = 1'b1;
      o_acc_rdata[ACC_ACTIVE]  = (r_state != ST_IDLE) && (i_acc_rd_loc == r_active);
      o_acc_rdata[ACC_SEIZED]  = |(r_seized & w_rd_mask);
      o_acc_rdata[ACC_PENDING] = |(r_req & ~w_rd_mask);
      o_acc_rdata[ACC_REQUSE]  = |(r_req & w_rd_mask);
    end
  end

endmodule

// File: tb/tb_tpm_locality_arb.sv
// tb/tb_tpm_locality_arb.sv - self-checking bench for tpm_locality_arb

module tb_tpm_locality_arb;

  localparam int NUM_LOC = 5;
`ifdef TPM_LOC_SEIZE_EN
  localparam bit SEIZE_EN = 1'b1;
`else
  localparam bit SEIZE_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               acc_wr = 1'b0;
  logic [2:0]         acc_loc = 3'd0;
  logic [7:0]         acc_wdata = 8'd0;
  logic [2:0]         rd_loc = 3'd0;
  logic [7:0]         rdata;
  logic               busy = 1'b0;
  logic [7:0]         locality;
  logic               active_valid;
  logic [NUM_LOC-1:0] req_pending;
  logic [NUM_LOC-1:0] been_seized;
  logic               abort;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tpm_locality_arb #(.NUM_LOC(NUM_LOC)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_acc_wr       (acc_wr),
    .i_acc_loc      (acc_loc),
    .i_acc_wdata    (acc_wdata),
    .i_acc_rd_loc   (rd_loc),
    .o_acc_rdata    (rdata),
    .i_cmd_busy     (busy),
    .o_locality     (locality),
    .o_active_valid (active_valid),
    .o_req_pending  (req_pending),
    .o_been_seized  (been_seized),
    .o_abort        (abort)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: owner index (-1 = none), a "waiting to release" flag,
  // and per-locality request / seized bit arrays.
  int                 m_owner;
  bit                 m_hold;
  logic [NUM_LOC-1:0] m_req;
  logic [NUM_LOC-1:0] m_seized;
  bit                 m_abort;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_hold = 0; m_req = '0; m_seized = '0; m_abort = 0;
    end else begin
      int  l;
      bit  ok, was_idle, was_hold, seized_now;
      l          = int'(acc_loc);
      ok         = acc_wr && (l < NUM_LOC);
      was_idle   = (m_owner < 0);
      was_hold   = m_hold;
      seized_now = 0;
      m_abort    = 0;
      if (ok && SEIZE_EN && acc_wdata[3] && !was_idle && l > m_owner) begin
        m_seized[m_owner] = 1'b1;
        m_req[l]  = 1'b0;
        m_owner   = l;
        m_hold    = 0;
        m_abort   = busy;
        seized_now = 1;
      end else if (ok && acc_wdata[5]) begin
        if (l == m_owner) begin
          if (!was_hold) begin
            if (busy) m_hold = 1;
            else m_owner = -1;
          end
        end else begin
          m_req[l] = 1'b0;
        end
      end else if (ok && acc_wdata[1] && l != m_owner) begin
        m_req[l] = 1'b1;
      end
      if (!seized_now && was_hold && !busy) begin
        m_owner = -1; m_hold = 0;
      end
      if (was_idle && !busy) begin
        for (int i = NUM_LOC - 1; i >= 0; i--) begin
          if (m_req[i]) begin
            m_owner  = i;
            m_req[i] = 1'b0;
            break;
          end
        end
      end
      if (ok && SEIZE_EN && acc_wdata[4]) m_seized[l] = 1'b0;
    end
  end

  function automatic logic [7:0] exp_rdata(input int r);
    logic [7:0] v;
    if (r >= NUM_LOC) return 8'hFF;
    v = 8'h80;
    v[5] = (m_owner == r);
    v[4] = m_seized[r];
    for (int i = 0; i < NUM_LOC; i++) if (i != r && m_req[i]) v[2] = 1'b1;
    v[1] = m_req[r];
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_locality", locality, (m_owner < 0) ? 8'h00 : (8'h01 << m_owner));
      chk("cyc_active_valid", active_valid, m_owner >= 0);
      chk("cyc_req_pending", req_pending, m_req);
      chk("cyc_been_seized", been_seized, m_seized);
      chk("cyc_abort", abort, m_abort);
      chk("cyc_rdata", rdata, exp_rdata(int'(rd_loc)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] l, input logic [7:0] d);
    acc_wr = 1'b1; acc_loc = l; acc_wdata = d;
    cyc();
    acc_wr = 1'b0; acc_wdata = 8'h00;
  endtask

  task automatic rd(input logic [2:0] l);
    rd_loc = l;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    // reset state
    rd(3'd0);
    chk("rst_locality", locality, 8'h00);
    chk("rst_valid", active_valid, 1'b0);
    chk("rst_req", req_pending, 5'b0);
    chk("rst_abort", abort, 1'b0);
    chk("rst_rdata0", rdata, 8'h80);

    // grant latency
    wr(3'd0, 8'h02);
    rd(3'd0);
    chk("grant0_locality", locality, 8'h01);
    chk("grant0_valid", active_valid, 1'b1);
    chk("grant0_rdata", rdata, 8'hA0);

    // relinquish with two pending, one idle cycle, highest wins
    wr(3'd2, 8'h02);
    wr(3'd3, 8'h02);
    wr(3'd0, 8'h20);
    chk("relinq_gap", locality, 8'h00);
    cyc();
    rd(3'd3);
    chk("next_grant3", locality, 8'h08);
    chk("next_req", req_pending, 5'b00100);
    chk("next_rdata3", rdata, 8'hA4);
    wr(3'd3, 8'h20);
    cyc();
    chk("grant2", locality, 8'h04);
    wr(3'd2, 8'h20);
    cyc();

    // relinquish while busy
    wr(3'd1, 8'h02);
    chk("own1", locality, 8'h02);
    busy = 1'b1;
    wr(3'd1, 8'h20);
    chk("hold_a", locality, 8'h02);
    cyc(); cyc();
    chk("hold_b", locality, 8'h02);
    busy = 1'b0;
    cyc();
    chk("hold_release", locality, 8'h00);
    cyc();

    // seize during command
    wr(3'd1, 8'h02);
    busy = 1'b1;
    wr(3'd4, 8'h08);
    rd(3'd1);
`ifdef TPM_LOC_SEIZE_EN
    chk("seize_locality", locality, 8'h10);
    chk("seize_abort", abort, 1'b1);
    chk("seize_rdata1", rdata, 8'h90);
    cyc();
    chk("seize_abort_once", abort, 1'b0);
    wr(3'd1, 8'h10);
    chk("seized_clear", been_seized, 5'b0);
    busy = 1'b0;
    wr(3'd4, 8'h20);
`else
    chk("noseize_locality", locality, 8'h02);
    chk("noseize_abort", abort, 1'b0);
    chk("noseize_req", req_pending, 5'b0);
    busy = 1'b0;
    wr(3'd1, 8'h20);
`endif
    cyc();

    // lower-priority seize ignored, out-of-range locality ignored
    wr(3'd3, 8'h02);
    wr(3'd2, 8'h08);
    chk("low_seize_loc", locality, 8'h08);
    chk("low_seize_abort", abort, 1'b0);
    wr(3'd6, 8'h02);
    rd(3'd6);
    chk("oor_rdata", rdata, 8'hFF);
    chk("oor_req", req_pending, 5'b0);

    // requests accumulated while release is pending; withdraw
    busy = 1'b1;
    wr(3'd3, 8'h20);
    wr(3'd0, 8'h02);
    wr(3'd1, 8'h02);
    wr(3'd4, 8'h02);
    wr(3'd1, 8'h20);
    chk("accum_req", req_pending, 5'b10001);
    busy = 1'b0;
    cyc();
    chk("accum_idle", locality, 8'h00);
    cyc();
    chk("accum_grant4", locality, 8'h10);
    chk("accum_req_after", req_pending, 5'b00001);
    wr(3'd0, 8'h22);
    chk("withdraw_beats_req", req_pending, 5'b00000);

    // seize while idle is ignored
    wr(3'd4, 8'h20);
    wr(3'd2, 8'h08);
    chk("idle_seize_valid", active_valid, 1'b0);

    // reset in the middle of a command
    wr(3'd2, 8'h02);
    busy = 1'b1;
    cyc();
    rst = 1'b1;
    #1;
    chk("async_rst_loc", locality, 8'h00);
    chk("async_rst_valid", active_valid, 1'b0);
    #2;
    rst = 1'b0;
    busy = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
